// File: rtl/multicycle_control_unit.sv
// ============================================================================
// Module   : multicycle_control_unit
// Brief    : Multi-cycle CPU control FSM with fetch/memory handshakes, signed
//            branches, ADDI, HALT/TRAP terminal states and a retire counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multicycle_control_unit #(
    parameter int INSTR_W    = 32,
    parameter int OPC_W      = 5,
    parameter int ALU_CTRL_W = 5,
    parameter int COUNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INSTR_W-1:0]    instruction,
    input  logic                  instr_valid,
    input  logic                  mem_ready,
    input  logic                  zero_flag,
    input  logic                  carry_flag,
    input  logic                  negative_flag,
    input  logic                  overflow_flag,
    output logic [ALU_CTRL_W-1:0] AluControl,
    output logic                  AluSrc,
    output logic                  MemtoReg,
    output logic                  RegDst,
    output logic                  RegWrite,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic                  Branch,
    output logic                  Jump,
    output logic                  branch_taken,
    output logic                  ir_write,
    output logic                  pc_inc,
    output logic                  pc_write,
    output logic [3:0]            current_state,
    output logic                  halted,
    output logic                  trap,
    output logic [COUNT_W-1:0]    instr_count
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXECUTE   = 4'd2,
        S_MEMORY    = 4'd3,
        S_WRITEBACK = 4'd4,
        S_HALT      = 4'd5,
        S_TRAP      = 4'd6
    } state_t;

    localparam logic [OPC_W-1:0] c_op_alu_last = OPC_W'(15);
    localparam logic [OPC_W-1:0] c_op_load     = OPC_W'(16);
    localparam logic [OPC_W-1:0] c_op_store    = OPC_W'(17);
    localparam logic [OPC_W-1:0] c_op_jump     = OPC_W'(18);
    localparam logic [OPC_W-1:0] c_op_beq      = OPC_W'(19);
    localparam logic [OPC_W-1:0] c_op_bne      = OPC_W'(20);
    localparam logic [OPC_W-1:0] c_op_blt      = OPC_W'(21);
    localparam logic [OPC_W-1:0] c_op_bgt      = OPC_W'(22);
    localparam logic [OPC_W-1:0] c_op_bge      = OPC_W'(23);
    localparam logic [OPC_W-1:0] c_op_ble      = OPC_W'(24);
    localparam logic [OPC_W-1:0] c_op_addi     = OPC_W'(25);
    localparam logic [OPC_W-1:0] c_op_halt     = OPC_W'(26);

    state_t               r_state;
    logic [INSTR_W-1:0]   r_ir;
    logic [COUNT_W-1:0]   r_count;

    logic [OPC_W-1:0]     w_opc;
    logic                 w_is_alu;
    logic                 w_is_load;
    logic                 w_is_store;
    logic                 w_is_jump;
    logic                 w_is_branch;
    logic                 w_is_addi;
    logic                 w_sign;
    logic                 w_cond;
    logic                 w_unused;

    assign w_opc       = r_ir[INSTR_W-1 -: OPC_W];
    assign w_is_alu    = (w_opc <= c_op_alu_last);
    assign w_is_load   = (w_opc == c_op_load);
    assign w_is_store  = (w_opc == c_op_store);
    assign w_is_jump   = (w_opc == c_op_jump);
    assign w_is_branch = (w_opc >= c_op_beq) && (w_opc <= c_op_ble);
    assign w_is_addi   = (w_opc == c_op_addi);

    // Signed less-than after SUB: N xor V
    assign w_sign = negative_flag ^ overflow_flag;

    // Operand bits of the IR and the carry flag are not consumed here
    assign w_unused = ^{carry_flag, r_ir[INSTR_W-OPC_W-1:0]};

    always_comb begin
        w_cond = 1'b0;
        case (w_opc)
            c_op_beq: w_cond = zero_flag;
            c_op_bne: w_cond = ~zero_flag;
            c_op_blt: w_cond = w_sign;
            c_op_bgt: w_cond = ~zero_flag & ~w_sign;
            c_op_bge: w_cond = ~w_sign;
            c_op_ble: w_cond = zero_flag | w_sign;
            default:  w_cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_ir    <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (instr_valid) begin
                        r_ir    <= instruction;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_opc < c_op_halt) begin
                        r_state <= S_EXECUTE;
                    end else if (w_opc == c_op_halt) begin
                        r_state <= S_HALT;
                    end else begin
                        r_state <= S_TRAP;
                    end
                end
                S_EXECUTE: begin
                    if (w_is_load || w_is_store) begin
                        r_state <= S_MEMORY;
                    end else if (w_is_jump || w_is_branch) begin
                        r_state <= S_FETCH;
                        r_count <= r_count + 1'b1;
                    end else begin
                        r_state <= S_WRITEBACK;
                    end
                end
                S_MEMORY: begin
                    if (mem_ready) begin
                        if (w_is_load) begin
                            r_state <= S_WRITEBACK;
                        end else begin
                            r_state <= S_FETCH;
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                S_WRITEBACK: begin
                    r_state <= S_FETCH;
                    r_count <= r_count + 1'b1;
                end
                S_HALT:  r_state <= S_HALT;
                S_TRAP:  r_state <= S_TRAP;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        AluControl   = '0;
        AluSrc       = 1'b0;
        MemtoReg     = 1'b0;
        RegDst       = 1'b0;
        RegWrite     = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        Branch       = 1'b0;
        Jump         = 1'b0;
        branch_taken = 1'b0;
        ir_write     = 1'b0;
        pc_inc       = 1'b0;
        pc_write     = 1'b0;
        halted       = 1'b0;
        trap         = 1'b0;
        case (r_state)
            S_FETCH: begin
                ir_write = instr_valid;
                pc_inc   = instr_valid;
            end
            S_EXECUTE: begin
                if (w_is_alu) begin
                    AluControl = ALU_CTRL_W'(w_opc);
                end else if (w_is_addi || w_is_load || w_is_store) begin
                    AluSrc = 1'b1;
                end else if (w_is_jump) begin
                    Jump     = 1'b1;
                    pc_write = 1'b1;
                end else if (w_is_branch) begin
                    Branch       = 1'b1;
                    AluControl   = ALU_CTRL_W'(1);
                    branch_taken = w_cond;
                    pc_write     = w_cond;
                end
            end
            S_MEMORY: begin
                // Address computation stays on the bus for the whole wait
                AluSrc   = 1'b1;
                MemRead  = w_is_load;
                MemWrite = w_is_store;
            end
            S_WRITEBACK: begin
                RegWrite = 1'b1;
                RegDst   = w_is_alu;
                MemtoReg = w_is_load;
            end
            S_HALT:  halted = 1'b1;
            S_TRAP:  trap   = 1'b1;
            default: ;
        endcase
    end

    assign current_state = r_state;
    assign instr_count   = r_count;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// ============================================================================
// Module   : tb_multicycle_control_unit
// Brief    : Self-checking bench; instruction-level reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        instr_valid, mem_ready;
    logic        zero_flag, carry_flag, negative_flag, overflow_flag;

    logic [4:0]  AluControl;
    logic        AluSrc, MemtoReg, RegDst, RegWrite, MemRead, MemWrite;
    logic        Branch, Jump, branch_taken, ir_write, pc_inc, pc_write;
    logic [3:0]  current_state;
    logic        halted, trap;
    logic [15:0] instr_count;

    logic [4:0]  AluControl2;
    logic        AluSrc2, MemtoReg2, RegDst2, RegWrite2, MemRead2, MemWrite2;
    logic        Branch2, Jump2, branch_taken2, ir_write2, pc_inc2, pc_write2;
    logic [3:0]  current_state2;
    logic        halted2, trap2;
    logic [1:0]  instr_count2;

    always #5 clk = ~clk;

    multicycle_control_unit dut (
        .clk(clk), .reset(reset), .instruction(instruction),
        .instr_valid(instr_valid), .mem_ready(mem_ready),
        .zero_flag(zero_flag), .carry_flag(carry_flag),
        .negative_flag(negative_flag), .overflow_flag(overflow_flag),
        .AluControl(AluControl), .AluSrc(AluSrc), .MemtoReg(MemtoReg),
        .RegDst(RegDst), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .Branch(Branch), .Jump(Jump),
        .branch_taken(branch_taken), .ir_write(ir_write), .pc_inc(pc_inc),
        .pc_write(pc_write), .current_state(current_state),
        .halted(halted), .trap(trap), .instr_count(instr_count)
    );

    multicycle_control_unit #(.COUNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .instruction(instruction),
        .instr_valid(instr_valid), .mem_ready(mem_ready),
        .zero_flag(zero_flag), .carry_flag(carry_flag),
        .negative_flag(negative_flag), .overflow_flag(overflow_flag),
        .AluControl(AluControl2), .AluSrc(AluSrc2), .MemtoReg(MemtoReg2),
        .RegDst(RegDst2), .RegWrite(RegWrite2), .MemRead(MemRead2),
        .MemWrite(MemWrite2), .Branch(Branch2), .Jump(Jump2),
        .branch_taken(branch_taken2), .ir_write(ir_write2), .pc_inc(pc_inc2),
        .pc_write(pc_write2), .current_state(current_state2),
        .halted(halted2), .trap(trap2), .instr_count(instr_count2)
    );

    typedef struct packed {
        logic [3:0] st;
        logic [4:0] aluc;
        logic alusrc, memtoreg, regdst, regwrite, memread, memwrite;
        logic branch, jump, bt, irw, pcinc, pcw, halted, trap;
    } exp_t;

    exp_t e;
    bit   exp_on = 1'b0;
    int   model_count = 0;
    int   vectors = 0;
    int   miscompares = 0;
    logic last_bt = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_on) begin
            chk("state",        32'(current_state), 32'(e.st));
            chk("AluControl",   32'(AluControl),    32'(e.aluc));
            chk("AluSrc",       32'(AluSrc),        32'(e.alusrc));
            chk("MemtoReg",     32'(MemtoReg),      32'(e.memtoreg));
            chk("RegDst",       32'(RegDst),        32'(e.regdst));
            chk("RegWrite",     32'(RegWrite),      32'(e.regwrite));
            chk("MemRead",      32'(MemRead),       32'(e.memread));
            chk("MemWrite",     32'(MemWrite),      32'(e.memwrite));
            chk("Branch",       32'(Branch),        32'(e.branch));
            chk("Jump",         32'(Jump),          32'(e.jump));
            chk("branch_taken", 32'(branch_taken),  32'(e.bt));
            chk("ir_write",     32'(ir_write),      32'(e.irw));
            chk("pc_inc",       32'(pc_inc),        32'(e.pcinc));
            chk("pc_write",     32'(pc_write),      32'(e.pcw));
            chk("halted",       32'(halted),        32'(e.halted));
            chk("trap",         32'(trap),          32'(e.trap));
            chk("instr_count",  32'(instr_count),   32'(model_count % 65536));
            chk("instr_count2", 32'(instr_count2),  32'(model_count % 4));
            if (current_state == 4'd2) last_bt = branch_taken;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expectation for one cycle: all controls low; don't-care inputs randomised
    task automatic setx(input int st);
        e = '0;
        e.st = 4'(st);
        instr_valid = 1'($urandom);
        mem_ready   = 1'($urandom);
        instruction = $urandom;
        {zero_flag, carry_flag, negative_flag, overflow_flag} = 4'($urandom);
    endtask

    task automatic do_reset();
        exp_on = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_count = 0;
        exp_on = 1'b1;
    endtask

    // One instruction from FETCH back to FETCH; flags = {Z,C,N,V}
    task automatic run_instr(input int opc, input int fw, input int mw,
                             input bit rst_mem, input int hold,
                             input bit use_fl, input logic [3:0] fl);
        logic [4:0] o;
        logic lt, tk;
        o = opc[4:0];
        exp_on = 1'b1;
        for (int i = 0; i < fw; i++) begin
            setx(0);
            instr_valid = 1'b0;
            step();
        end
        setx(0);
        instr_valid = 1'b1;
        instruction = {o, 27'($urandom)};
        e.irw = 1'b1;
        e.pcinc = 1'b1;
        step();
        setx(1);
        step();
        if (opc >= 26) begin
            for (int i = 0; i < hold; i++) begin
                setx(opc == 26 ? 5 : 6);
                e.halted = (opc == 26);
                e.trap   = (opc != 26);
                step();
            end
            return;
        end
        setx(2);
        if (use_fl) {zero_flag, carry_flag, negative_flag, overflow_flag} = fl;
        if (opc < 16) begin
            e.aluc = o;
        end else if (opc == 16 || opc == 17 || opc == 25) begin
            e.alusrc = 1'b1;
        end else if (opc == 18) begin
            e.jump = 1'b1;
            e.pcw = 1'b1;
        end else begin
            lt = negative_flag ^ overflow_flag;
            case (opc)
                19:      tk = zero_flag;
                20:      tk = !zero_flag;
                21:      tk = lt;
                22:      tk = !zero_flag && !lt;
                23:      tk = !lt;
                default: tk = zero_flag || lt;
            endcase
            e.branch = 1'b1;
            e.aluc = 5'd1;
            e.bt = tk;
            e.pcw = tk;
        end
        step();
        if (opc == 18 || (opc >= 19 && opc <= 24)) begin
            model_count++;
            return;
        end
        if (opc == 16 || opc == 17) begin
            for (int i = 0; i < mw; i++) begin
                setx(3);
                mem_ready = 1'b0;
                e.alusrc = 1'b1;
                e.memread = (opc == 16);
                e.memwrite = (opc == 17);
                if (rst_mem && i == mw - 1) begin
                    reset = 1'b1;
                    step();
                    reset = 1'b0;
                    model_count = 0;
                    return;
                end
                step();
            end
            setx(3);
            mem_ready = 1'b1;
            e.alusrc = 1'b1;
            e.memread = (opc == 16);
            e.memwrite = (opc == 17);
            step();
            if (opc == 17) begin
                model_count++;
                return;
            end
        end
        setx(4);
        e.regwrite = 1'b1;
        e.regdst = (opc < 16);
        e.memtoreg = (opc == 16);
        step();
        model_count++;
    endtask

    initial begin
        int r, opc;
        reset = 1'b1;
        instruction = '0;
        instr_valid = 1'b0;
        mem_ready = 1'b0;
        {zero_flag, carry_flag, negative_flag, overflow_flag} = 4'b0;
        step();
        step();
        reset = 1'b0;

        chk("reset_state", 32'(current_state), 32'd0);
        chk("reset_count", 32'(instr_count), 32'd0);

        run_instr(0, 0, 0, 0, 0, 0, 4'b0);
        chk("add_count", 32'(instr_count), 32'd1);
        run_instr(16, 0, 3, 0, 0, 0, 4'b0);
        chk("load_count", 32'(instr_count), 32'd2);

        run_instr(21, 0, 0, 0, 0, 1, 4'b0011);
        chk("blt_n1v1", 32'(last_bt), 32'd0);
        run_instr(21, 0, 0, 0, 0, 1, 4'b0010);
        chk("blt_n1v0", 32'(last_bt), 32'd1);
        run_instr(24, 0, 0, 0, 0, 1, 4'b1000);
        chk("ble_z1", 32'(last_bt), 32'd1);
        run_instr(22, 0, 0, 0, 0, 1, 4'b0000);
        chk("bgt_000", 32'(last_bt), 32'd1);
        run_instr(20, 0, 0, 0, 0, 1, 4'b1000);
        chk("bne_z1", 32'(last_bt), 32'd0);

        run_instr(3, 5, 0, 0, 0, 0, 4'b0);
        chk("fetch_wait_count", 32'(instr_count), 32'd8);

        run_instr(26, 0, 0, 0, 10, 0, 4'b0);
        chk("halt_count", 32'(instr_count), 32'd8);
        do_reset();
        chk("halt_reset_state", 32'(current_state), 32'd0);
        chk("halt_reset_count", 32'(instr_count), 32'd0);

        run_instr(31, 0, 0, 0, 6, 0, 4'b0);
        chk("trap_held", 32'(trap), 32'd1);
        do_reset();

        run_instr(17, 0, 3, 1, 0, 0, 4'b0);
        chk("rst_mem_state", 32'(current_state), 32'd0);
        chk("rst_mem_memwrite", 32'(MemWrite), 32'd0);

        for (int i = 0; i < 5; i++) run_instr(i + 2, 0, 0, 0, 0, 0, 4'b0);
        chk("count2_wrap", 32'(instr_count2), 32'd1);
        chk("count16_five", 32'(instr_count), 32'd5);

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            if (r < 3)      opc = 26;
            else if (r < 6) opc = $urandom_range(27, 31);
            else            opc = $urandom_range(0, 25);
            if (opc >= 26) begin
                run_instr(opc, $urandom_range(0, 2), 0, 0, 3, 0, 4'b0);
                do_reset();
            end else begin
                run_instr(opc, ($urandom % 2) ? $urandom_range(0, 3) : 0,
                          $urandom_range(0, 3),
                          ((opc == 16 || opc == 17) && r < 10), 0, 0, 4'b0);
            end
        end

        exp_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Parametrised, next-generation multi-cycle control FSM for the CPU datapath. Latches the fetched instruction into an internal IR and sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK per instruction class. Adds the following:
- instruction-fetch and data-memory ready handshakes (wait states)
- signed branch conditions
- an ADDI immediate op
- HALT and TRAP terminal states
- a retired-instruction counter

Sits between instruction/data memory interfaces and the ALU/register-file/PC datapath.

Parameters:
INSTR_W, 32, instruction width; opcode is ir[INSTR_W-1 -: OPC_W].
OPC_W, 5, opcode width; must be >= 5.
ALU_CTRL_W, 5, AluControl width; must be >= 5.
COUNT_W, 16, width of the retired-instruction counter.

Ports:
clk  input  1  system clock, all state updates on its rising edge
reset  input  1  synchronous, active-high reset
instruction  input  INSTR_W  instruction word from instruction memory
instr_valid  input  1  instruction word valid this cycle
mem_ready  input  1  data memory completes the current read/write this cycle
zero_flag, carry_flag, negative_flag, overflow_flag  input  1 each  ALU flags (Z, C, N, V)
AluControl  output  ALU_CTRL_W  ALU operation select
AluSrc, MemtoReg, RegDst, RegWrite, MemRead, MemWrite, Branch, Jump, branch_taken  output  1 each  datapath controls
ir_write  output  1  capture the instruction into the IR
pc_inc  output  1  PC <= PC+1
pc_write  output  1  PC <= branch/jump target
current_state  output  4  FSM state encoding
halted  output  1  FSM is in HALT
trap  output  1  FSM is in TRAP (illegal opcode)
instr_count  output  COUNT_W  count of retired instructions

Behaviour:
- States: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=5, TRAP=6. Codes 7-15 are unreachable and any of them → FETCH.
- Reset (sync, clk edge with reset=1), regardless of state:
  - state=FETCH, IR=0, instr_count=0.
  - Reset is honoured mid-MEMORY wait and in HALT/TRAP.
- Control outputs are combinational from state and IR; every output not listed for a state is 0 (AluControl=0).
- FETCH:
  - If instr_valid: ir_write=1, pc_inc=1, IR<=instruction, → DECODE.
  - Else stay in FETCH with all controls 0.
- DECODE: no controls asserted. Next state by opcode:
  - 0-25 → EXECUTE
  - 26 (HALT) → HALT
  - 27 and above → TRAP
- EXECUTE:
  - ALU ops 0-15: AluControl=opcode, AluSrc=0 → WRITEBACK.
  - ADDI (25): AluControl=0, AluSrc=1 → WRITEBACK.
  - LOAD (16) / STORE (17): AluControl=0 (ADD), AluSrc=1 → MEMORY.
  - JUMP (18): Jump=1, pc_write=1 → FETCH.
  - Branches (19-24): Branch=1, AluControl=1 (SUB), AluSrc=0, pc_write=branch_taken → FETCH. branch_taken uses the flags sampled this cycle, with S = N xor V:
    - BEQ(19): Z
    - BNE(20): !Z
    - BLT(21): S
    - BGT(22): !Z and !S
    - BGE(23): !S
    - BLE(24): Z or S
  - branch_taken=0 outside EXECUTE-branch.
  - carry_flag is not used by any branch.
- MEMORY:
  - LOAD: MemRead=1 and AluControl=0/AluSrc=1 held.
  - STORE: MemWrite=1 and AluControl=0/AluSrc=1 held.
  - Stay while mem_ready=0 (unbounded wait).
  - On mem_ready=1: LOAD → WRITEBACK; STORE → FETCH.
- WRITEBACK: RegWrite=1 →FETCH.
  - ALU ops: RegDst=1, MemtoReg=0.
  - ADDI: RegDst=0, MemtoReg=0.
  - LOAD: RegDst=0, MemtoReg=1.
- HALT: halted=1, all controls 0; stays until reset. instr_valid and mem_ready are ignored.
- TRAP: trap=1, all controls 0; stays until reset.
- Retirement: instr_count +1 on every transition into FETCH from EXECUTE, MEMORY or WRITEBACK. It wraps modulo 2^COUNT_W. HALT and illegal opcodes do not retire.
- Cycle counts with no waits:
  - ALU/ADDI: 4
  - LOAD: 5
  - STORE: 4
  - JUMP/branch: 3
  - plus 1 cycle per FETCH or MEMORY wait.

Test Plan:
- ADD (opcode 0), instr_valid=1 throughout:
  - states 0,1,2,4,0.
  - EXECUTE: AluControl=00000, AluSrc=0.
  - WRITEBACK: RegWrite=1, RegDst=1.
  - instr_count 0→1.
- LOAD (16) with mem_ready low 3 cycles:
  - MEMORY held 4 cycles with MemRead=1.
  - Then WRITEBACK with MemtoReg=1, RegWrite=1, RegDst=0.
  - Total 8 cycles from FETCH to FETCH.
- Branches, EXECUTE branch_taken/pc_write:
  - BLT with N=1, V=1 → branch_taken=0.
  - BLT with N=1, V=0 → 1.
  - BLE with Z=1 → 1.
  - BGT with Z=0, N=0, V=0 → 1.
  - BNE with Z=1 → 0.
  - Branch=1 and AluControl=00001 in every case.
- instr_valid=0 for 5 cycles in FETCH:
  - state stays 0, ir_write=0, pc_inc=0.
  - Asserting instr_valid → ir_write=1 that cycle, DECODE next.
- Opcode 26:
  - DECODE→HALT, halted=1.
  - 10 further cycles unchanged, instr_count unchanged.
  - reset=1 for one edge → FETCH, instr_count=0.
- Opcode 31:
  - trap=1 and held.
  - Separately: reset asserted mid-MEMORY STORE wait → next edge state=0, MemWrite=0.
  - COUNT_W=2: 5 retirements → instr_count=1.
